// File: rtl/sram_sequencer.sv
// Sequences host and tag-RAM identity-fill accesses onto an asynchronous SRAM bus.
// Every access runs IDLE -> ADDR -> STROBE (STROBE_CYCLES) -> RECOVER, and all outputs are registered.
module sram_sequencer #(
  parameter int STROBE_CYCLES = 2,
  parameter int FILL_ENTRIES  = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        host_req,
  input  logic        host_tag,
  input  logic        host_we,
  input  logic [20:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  input  logic        fill_start,
  output logic        fill_busy,
  output logic        fill_done,
  output logic [20:0] baddress,
  output logic [7:0]  bdata_out,
  output logic        bdata_oe,
  input  logic [7:0]  bdata_in,
  output logic        _ce_ram,
  output logic        _ce_tag,
  output logic        _we_ram
);

  localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT   = CW'(STROBE_CYCLES - 1);
  localparam logic [11:0]   LAST_ENTRY = 12'(FILL_ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, ADDR, STROBE, RECOVER} state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_we, w_we_next;
  logic          r_host, w_host_next;
  logic [11:0]   r_entry, w_entry_next;
  logic          r_fill_busy, w_fill_busy_next;
  logic          r_fill_done, w_fill_done_next;
  logic          r_host_ack, w_host_ack_next;
  logic [7:0]    r_host_rdata, w_host_rdata_next;
  logic [20:0]   r_baddress, w_baddress_next;
  logic [7:0]    r_bdata_out, w_bdata_out_next;
  logic          r_bdata_oe, w_bdata_oe_next;
  logic          r_ce_ram, w_ce_ram_next;
  logic          r_ce_tag, w_ce_tag_next;
  logic          r_we_ram, w_we_ram_next;
  logic          w_grant_tag, w_grant_we;

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_we_next         = r_we;
    w_host_next       = r_host;
    w_entry_next      = r_entry;
    w_fill_busy_next  = r_fill_busy;
    w_fill_done_next  = 1'b0;
    w_host_ack_next   = 1'b0;
    w_host_rdata_next = r_host_rdata;
    w_baddress_next   = r_baddress;
    w_bdata_out_next  = r_bdata_out;
    w_bdata_oe_next   = r_bdata_oe;
    w_ce_ram_next     = r_ce_ram;
    w_ce_tag_next     = r_ce_tag;
    w_we_ram_next     = r_we_ram;
    w_grant_tag       = 1'b0;
    w_grant_we        = 1'b0;

    if (fill_start && !r_fill_busy) begin
      w_fill_busy_next = 1'b1;
      w_entry_next     = '0;
    end

    case (r_state)
      IDLE: begin
        if (host_req || r_fill_busy) begin
          // Host has strict priority; a fill access only starts from IDLE, so it is never split.
          if (host_req) begin
            w_grant_tag      = host_tag;
            w_grant_we       = host_we;
            w_baddress_next  = host_addr;
            w_bdata_out_next = host_wdata;
            w_host_next      = 1'b1;
          end else begin
            w_grant_tag      = 1'b1;
            w_grant_we       = 1'b1;
            w_baddress_next  = {9'b0, r_entry};
            w_bdata_out_next = {4'h0, r_entry[3:0]};
            w_host_next      = 1'b0;
          end
          w_we_next       = w_grant_we;
          w_ce_ram_next   = w_grant_tag;
          w_ce_tag_next   = !w_grant_tag;
          w_we_ram_next   = 1'b1;
          w_bdata_oe_next = w_grant_we;
          w_cnt_next      = '0;
          w_state_next    = ADDR;
        end
      end
      ADDR: begin
        w_we_ram_next = !r_we;
        w_state_next  = STROBE;
      end
      STROBE: begin
        if (r_cnt == LAST_CNT) begin
          w_state_next  = RECOVER;
          w_ce_ram_next = 1'b1;
          w_ce_tag_next = 1'b1;
          w_we_ram_next = 1'b1;
          if (!r_we) w_host_rdata_next = bdata_in;
          if (r_host) begin
            w_host_ack_next = 1'b1;
          end else if (r_entry == LAST_ENTRY) begin
            w_fill_busy_next = 1'b0;
            w_fill_done_next = 1'b1;
          end else begin
            w_entry_next = r_entry + 12'd1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      RECOVER: begin
        w_bdata_oe_next = 1'b0;
        w_state_next    = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_host       <= 1'b0;
      r_entry      <= '0;
      r_fill_busy  <= 1'b0;
      r_fill_done  <= 1'b0;
      r_host_ack   <= 1'b0;
      r_host_rdata <= '0;
      r_baddress   <= '0;
      r_bdata_out  <= '0;
      r_bdata_oe   <= 1'b0;
      r_ce_ram     <= 1'b1;
      r_ce_tag     <= 1'b1;
      r_we_ram     <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_we         <= w_we_next;
      r_host       <= w_host_next;
      r_entry      <= w_entry_next;
      r_fill_busy  <= w_fill_busy_next;
      r_fill_done  <= w_fill_done_next;
      r_host_ack   <= w_host_ack_next;
      r_host_rdata <= w_host_rdata_next;
      r_baddress   <= w_baddress_next;
      r_bdata_out  <= w_bdata_out_next;
      r_bdata_oe   <= w_bdata_oe_next;
      r_ce_ram     <= w_ce_ram_next;
      r_ce_tag     <= w_ce_tag_next;
      r_we_ram     <= w_we_ram_next;
    end
  end

  assign host_ack   = r_host_ack;
  assign host_rdata = r_host_rdata;
  assign fill_busy  = r_fill_busy;
  assign fill_done  = r_fill_done;
  assign baddress   = r_baddress;
  assign bdata_out  = r_bdata_out;
  assign bdata_oe   = r_bdata_oe;
  assign _ce_ram    = r_ce_ram;
  assign _ce_tag    = r_ce_tag;
  assign _we_ram    = r_we_ram;

endmodule

// File: tb/tb_sram_sequencer.sv
// Self-checking bench for sram_sequencer: an SRAM bus model, a table of host vectors,
// randomized host traffic against a memory-level reference, plus fill, interleave and reset sequences.
module tb_sram_sequencer;
  localparam int S  = 2;
  localparam int FE = 4096;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        host_req = 1'b0, host_tag = 1'b0, host_we = 1'b0;
  logic [20:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        fill_start = 1'b0;
  logic [7:0]  bdata_in = '0;
  logic        host_ack, fill_busy, fill_done, bdata_oe, _ce_ram, _ce_tag, _we_ram;
  logic [7:0]  host_rdata, bdata_out;
  logic [20:0] baddress;

  sram_sequencer #(.STROBE_CYCLES(S), .FILL_ENTRIES(FE)) dut (
    .clock(clock), .reset(reset), .host_req(host_req), .host_tag(host_tag), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .fill_start(fill_start), .fill_busy(fill_busy), .fill_done(fill_done), .baddress(baddress),
    .bdata_out(bdata_out), .bdata_oe(bdata_oe), .bdata_in(bdata_in),
    ._ce_ram(_ce_ram), ._ce_tag(_ce_tag), ._we_ram(_we_ram));

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Unwritten locations read back a fixed address-derived pattern, known to bus model and reference alike.
  function automatic logic [7:0] dflt(input bit tag, input logic [20:0] a);
    return a[7:0] ^ (tag ? 8'h69 : 8'h96);
  endfunction

  logic [7:0] ram_mem[int];
  logic [7:0] tag_mem[int];
  logic [7:0] ref_ram[int];
  logic [7:0] ref_tag[int];

  function automatic logic [7:0] sram_rd(input bit tag, input logic [20:0] a);
    if (tag) return tag_mem.exists(int'(a)) ? tag_mem[int'(a)] : dflt(1'b1, a);
    return ram_mem.exists(int'(a)) ? ram_mem[int'(a)] : dflt(1'b0, a);
  endfunction

  function automatic logic [7:0] ref_rd(input bit tag, input logic [20:0] a);
    if (tag) return ref_tag.exists(int'(a)) ? ref_tag[int'(a)] : dflt(1'b1, a);
    return ref_ram.exists(int'(a)) ? ref_ram[int'(a)] : dflt(1'b0, a);
  endfunction

  typedef struct { bit tag; logic [20:0] a; logic [7:0] d; } wr_t;
  wr_t wlog[$];
  logic prev_we = 1'b1;
  int   ce_both = 0;
  int   done_pulses = 0;

  // Asynchronous SRAM model: stores on a low write strobe, logs each write once, returns read data.
  always @(negedge clock) begin
    if (!_ce_ram && !_ce_tag) ce_both++;
    if (fill_done) done_pulses++;
    if (!_we_ram) begin
      if (!_ce_tag) tag_mem[int'(baddress)] = bdata_out;
      else if (!_ce_ram) ram_mem[int'(baddress)] = bdata_out;
      if (prev_we) wlog.push_back('{!_ce_tag, baddress, bdata_out});
    end
    prev_we = _we_ram;
    bdata_in = !_ce_tag ? sram_rd(1'b1, baddress) : (!_ce_ram ? sram_rd(1'b0, baddress) : 8'h00);
  end

  task automatic check_reset_vals(input string p);
    check({p, "_ce_ram"}, _ce_ram, 1);
    check({p, "_ce_tag"}, _ce_tag, 1);
    check({p, "_we_ram"}, _we_ram, 1);
    check({p, "_bdata_oe"}, bdata_oe, 0);
    check({p, "_baddress"}, baddress, 0);
    check({p, "_bdata_out"}, bdata_out, 0);
    check({p, "_host_ack"}, host_ack, 0);
    check({p, "_host_rdata"}, host_rdata, 0);
    check({p, "_fill_busy"}, fill_busy, 0);
    check({p, "_fill_done"}, fill_done, 0);
  endtask

  // Called at a negedge; returns at the negedge after the ack cycle.
  task automatic host_txn(input bit tag, input bit we, input logic [20:0] a, input logic [7:0] wd,
                          input int exp_lat, input bit chk_bus,
                          output logic [7:0] rd, output int lat, output int log_at_ack);
    int ce_r = 0, ce_t = 0, wl = 0, oe = 0, bad_addr = 0, bad_data = 0;
    bit got = 0;
    rd = 8'h00; lat = 0; log_at_ack = -1;
    host_req = 1'b1; host_tag = tag; host_we = we; host_addr = a; host_wdata = wd;
    for (int n = 1; n <= 60 && !got; n++) begin
      @(negedge clock);
      if (!_ce_ram) ce_r++;
      if (!_ce_tag) ce_t++;
      if (bdata_oe) oe++;
      if (!_we_ram) begin
        wl++;
        if (bdata_out !== wd) bad_data++;
      end
      if ((!_ce_ram || !_ce_tag) && baddress !== a) bad_addr++;
      if (host_ack) begin
        got = 1; lat = n; rd = host_rdata; log_at_ack = wlog.size();
      end
    end
    host_req = 1'b0;
    check("ack_seen", got, 1);
    @(negedge clock);
    if (bdata_oe) oe++;
    check("ack_one_cycle", host_ack, 0);
    check("ack_latency", lat, exp_lat);
    if (chk_bus) begin
      check("ce_target_cycles", tag ? ce_t : ce_r, S + 1);
      check("ce_other_cycles", tag ? ce_r : ce_t, 0);
      check("we_low_cycles", wl, we ? S : 0);
      check("oe_cycles", oe, we ? S + 2 : 0);
      check("bus_addr", bad_addr, 0);
      check("bus_wdata", bad_data, 0);
    end
    $display("txn tag=%0d we=%0d addr=%06h wdata=%02h rdata=%02h latency=%0d", tag, we, a, wd, rd, lat);
  endtask

  typedef struct { bit tag; bit we; logic [20:0] a; logic [7:0] wd; logic [7:0] exp_rd; } vec_t;
  vec_t tbl[8];

  initial begin
    logic [7:0] rd;
    int lat, la, bad, found;

    tbl[0] = '{1'b0, 1'b0, 21'h0C010, 8'h00, 8'h5A};
    tbl[1] = '{1'b1, 1'b1, 21'h00123, 8'hA5, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 21'h00123, 8'h00, 8'hA5};
    tbl[3] = '{1'b0, 1'b1, 21'h1FFFFF, 8'h3C, 8'h00};
    tbl[4] = '{1'b0, 1'b0, 21'h1FFFFF, 8'h00, 8'h3C};
    tbl[5] = '{1'b1, 1'b0, 21'h1FFFFF, 8'h00, 8'h96};
    tbl[6] = '{1'b0, 1'b1, 21'h00000, 8'hFF, 8'h00};
    tbl[7] = '{1'b0, 1'b0, 21'h00000, 8'h00, 8'hFF};
    ram_mem[int'(21'h0C010)] = 8'h5A;
    ref_ram[int'(21'h0C010)] = 8'h5A;

    repeat (3) @(negedge clock);
    check_reset_vals("rst0");
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      host_txn(tbl[i].tag, tbl[i].we, tbl[i].a, tbl[i].wd, S + 2, 1'b1, rd, lat, la);
      if (tbl[i].we) begin
        if (tbl[i].tag) ref_tag[int'(tbl[i].a)] = tbl[i].wd;
        else ref_ram[int'(tbl[i].a)] = tbl[i].wd;
      end else begin
        check("tbl_rdata", rd, tbl[i].exp_rd);
      end
    end

    for (int i = 0; i < 40; i++) begin
      bit t, w;
      logic [20:0] a;
      logic [7:0] d;
      t = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = {2'($urandom_range(0, 3)), 15'b0, 4'($urandom_range(0, 15))};
      d = 8'($urandom);
      host_txn(t, w, a, d, S + 2, 1'b1, rd, lat, la);
      if (w) begin
        if (t) ref_tag[int'(a)] = d;
        else ref_ram[int'(a)] = d;
      end else begin
        check("rand_rdata", rd, ref_rd(t, a));
      end
    end

    // Full identity fill, host read interleaved at entry 7, and a stray fill_start while busy.
    wlog.delete();
    done_pulses = 0;
    fill_start = 1'b1;
    @(negedge clock);
    fill_start = 1'b0;
    check("fill_busy_set", fill_busy, 1);
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clock);
      if (!_ce_tag && baddress == 21'd7) found = 1;
    end
    check("entry7_seen", found, 1);
    host_txn(1'b0, 1'b0, 21'h0C010, 8'h00, 2 * S + 4, 1'b0, rd, lat, la);
    check("fill_host_rdata", rd, 8'h5A);
    check("fill_host_order", la, 8);
    found = 0;
    for (int n = 0; n < 1000 && !found; n++) begin
      @(negedge clock);
      if (wlog.size() >= 100) found = 1;
    end
    fill_start = 1'b1;
    @(negedge clock);
    fill_start = 1'b0;
    found = 0;
    for (int n = 0; n < FE * (S + 3) + 400 && !found; n++) begin
      @(negedge clock);
      if (fill_done) begin
        found = 1;
        check("busy_falls_with_done", fill_busy, 0);
      end
    end
    check("fill_done_seen", found, 1);
    repeat (10) @(negedge clock);
    check("fill_done_once", done_pulses, 1);
    check("fill_write_count", wlog.size(), FE);
    bad = 0;
    for (int i = 0; i < wlog.size(); i++) begin
      logic [11:0] e;
      e = 12'(i);
      if (!wlog[i].tag || wlog[i].a !== {9'b0, e} || wlog[i].d !== {4'h0, e[3:0]}) bad++;
    end
    check("fill_sequence", bad, 0);
    if (wlog.size() > 18) begin
      check("fill_entry12_addr", wlog[18].a, 21'h00012);
      check("fill_entry12_data", wlog[18].d, 8'h02);
    end
    for (int i = 0; i < FE; i++) ref_tag[i] = {4'h0, 4'(i)};
    host_txn(1'b1, 1'b0, 21'h00012, 8'h00, S + 2, 1'b1, rd, lat, la);
    check("post_fill_tag_read", rd, ref_rd(1'b1, 21'h00012));

    // Reset lands in STROBE of a host write queued behind an active fill.
    fill_start = 1'b1;
    @(negedge clock);
    fill_start = 1'b0;
    repeat (12) @(negedge clock);
    host_req = 1'b1; host_tag = 1'b1; host_we = 1'b1; host_addr = 21'h00123; host_wdata = 8'h77;
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clock);
      if (!_we_ram && !_ce_tag && baddress == 21'h00123) found = 1;
    end
    check("host_strobe_seen", found, 1);
    reset = 1'b1;
    host_req = 1'b0;
    @(negedge clock);
    check_reset_vals("rst1");
    reset = 1'b0;
    bad = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if (host_ack || fill_done || fill_busy || !_ce_ram || !_ce_tag || !_we_ram || bdata_oe) bad++;
    end
    check("no_resume_after_reset", bad, 0);
    check("ce_exclusive", ce_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_sequencer.md
SRAM_SEQUENCER -- requirements
Module: sram_sequencer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  STROBE_CYCLES  2  cycles chip-enable and strobe stay asserted per access (>=1)
  FILL_ENTRIES  4096  tag-RAM entries written by one fill run (<=4096)
REQ-002 SHALL use one clock; reset is synchronous and active-high; ports named clock and reset.
REQ-003 SHALL have ports, one per line: name  direction  width  meaning.
  clock  in  1  system clock
  reset  in  1  synchronous active-high reset
  host_req  in  1  host access request, level, held until host_ack
  host_tag  in  1  1 = tag (MMU map) RAM, 0 = main RAM
  host_we  in  1  1 = write
  host_addr  in  21  host SRAM address
  host_wdata  in  8  host write data
  host_ack  out  1  one-cycle completion pulse
  host_rdata  out  8  read data, valid from host_ack onward
  fill_start  in  1  one-cycle pulse, start tag-RAM identity fill
  fill_busy  out  1  fill run in progress
  fill_done  out  1  one-cycle pulse, fill finished
  baddress  out  21  SRAM address
  bdata_out  out  8  SRAM write data
  bdata_oe  out  1  drive bdata_out onto SRAM bus
  bdata_in  in  8  SRAM read data
  _ce_ram  out  1  main RAM chip enable, active low
  _ce_tag  out  1  tag RAM chip enable, active low
  _we_ram  out  1  SRAM write strobe, active low

Function
REQ-004 SHALL implement FSM states IDLE, ADDR, STROBE, RECOVER; all outputs registered.
REQ-005 SHALL, in IDLE, grant host if host_req=1, else grant fill if fill_busy=1, else stay IDLE (host strict priority).
REQ-006 SHALL on grant latch address, write data, we and target (fill: target tag, we=1) and enter ADDR.
REQ-007 SHALL in ADDR drive baddress and selected chip enable low, _we_ram=1; bdata_oe=1 if write; one cycle.
REQ-008 SHALL in STROBE hold ADDR signals and assert _we_ram=0 if write, for exactly STROBE_CYCLES cycles.
REQ-009 SHALL, on a read, capture bdata_in into host_rdata on the last STROBE cycle.
REQ-010 SHALL in RECOVER deassert both chip enables and _we_ram, keep bdata_oe one more cycle for writes, then return to IDLE.
REQ-011 SHALL pulse host_ack in RECOVER of a host access; host latency req-seen-in-IDLE to ack = STROBE_CYCLES+2 cycles.
REQ-012 SHALL sample host_req only in IDLE; a req still high in the IDLE after ack is a new access.
REQ-013 SHALL never assert _ce_ram and _ce_tag low simultaneously.
REQ-014 SHALL, on fill_start with fill_busy=0, set fill_busy=1 and clear a 12-bit entry counter to 0.
REQ-015 SHALL, per fill access, write data {4'h0, entry[3:0]} to tag address {9'b0, entry[11:0]}, then increment entry.
REQ-016 SHALL, after entry FILL_ENTRIES-1 completes (RECOVER), clear fill_busy and pulse fill_done same cycle; no counter wrap past it.
REQ-017 SHALL ignore fill_start while fill_busy=1.
REQ-018 SHALL, when host_req arrives during a fill access, finish that fill access then serve host next; the fill entry is neither lost nor repeated.

Reset
REQ-019 SHALL on reset: state IDLE, _ce_ram=1, _ce_tag=1, _we_ram=1, bdata_oe=0, baddress=0, bdata_out=0, host_ack=0, host_rdata=0, fill_busy=0, fill_done=0, entry=0.
REQ-020 SHALL on reset mid-access or mid-fill abort immediately to REQ-019 values; no ack or done pulse; fill does not resume.

Verification
REQ-021 Host read main RAM, addr 0x0C010, bdata_in=0x5A -> _ce_ram low 3 cycles, _we_ram high, ack 4 cycles after req seen, host_rdata=0x5A.
REQ-022 Host write tag, addr 0x00123, data 0xA5 -> _ce_tag low, _we_ram low exactly 2 cycles, bdata_oe high ADDR..RECOVER, bdata_out=0xA5.
REQ-023 fill_start with FILL_ENTRIES=4096 -> 4096 tag writes, entry 0x012 writes 0x02 at 0x00012, fill_done once, fill_busy falls same cycle.
REQ-024 host_req raised during fill entry 7 -> entry 7 completes, host access next, fill resumes at entry 8; no entry skipped/repeated.
REQ-025 reset during STROBE of a host write, then second fill_start during busy -> all outputs to reset values, no ack; fill_start during busy ignored.
